mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/simplerv_pkg.sv | 24 ++
 rtl/arb_prio.sv | 30 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplerv_pkg.sv
// Shared types and constants for the memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package simplerv_pkg;

    localparam int ACCESS_W = 3;
    localparam logic [ACCESS_W-1:0] ACCESS_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // Command captured at arbitration and replayed to memory one cycle later.
    typedef struct packed {
        logic                is_fetch;
        logic                we;
        logic [ACCESS_W-1:0] access;
        logic [31:0]         addr;
        logic [31:0]         wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_prio.sv
// Fixed data-over-fetch priority with an anti-starvation override for fetch.
// Latency: purely combinational.
// Backpressure: no grant when arb_en is low; a losing request simply stays pending.
module arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       arb_en,
    input  logic       if_req,
    input  logic       d_req,
    input  logic [3:0] streak,
    output logic       grant_if,
    output logic       grant_d
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Data wins unless fetch is contending and has lost LIMIT times in a row.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (arb_en) begin
            if (d_req && !(if_req && (streak >= LIMIT))) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory (optional stats: MEM_ARB_STATS_EN).
// Latency: gnt in cycle 0, memory strobe in cycle 1, rvalid in cycle 2; one access per 2 cycles.
// Backpressure: requesters hold until gnt; no grant while an access is being issued.
module mem_arbiter
    import simplerv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [31:0]         if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [31:0]         if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ACCESS_W-1:0] d_access,
    input  logic [31:0]         d_addr,
    input  logic [31:0]         d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [31:0]         d_rdata,
    output logic                mem_load,
    output logic                mem_store,
    output logic [ACCESS_W-1:0] mem_access,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    output logic                busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]         stat_if_grants,
    output logic [31:0]         stat_d_grants,
    output logic [31:0]         stat_contended
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state_q, state_d;
    logic [3:0] streak_q, streak_d;
    mem_cmd_t   cmd_q, cmd_d;
    logic       arb_en;
    logic       grant_if;
    logic       grant_d;

    // Arbitration only in IDLE/RESP; reset suppresses grants so outputs stay quiet.
    assign arb_en = rst && (state_q != ISSUE);

    arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .arb_en  (arb_en),
        .if_req  (if_req),
        .d_req   (d_req),
        .streak  (streak_q),
        .grant_if(grant_if),
        .grant_d (grant_d)
    );

    // Next state, captured command and starvation streak.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        streak_d = streak_q;
        case (state_q)
            IDLE:    if (grant_if || grant_d) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = (grant_if || grant_d) ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
        if (grant_if) begin
            cmd_d    = '{is_fetch: 1'b1, we: 1'b0, access: ACCESS_WORD, addr: if_addr, wdata: 32'd0};
            streak_d = 4'd0;
        end else if (grant_d) begin
            cmd_d    = '{is_fetch: 1'b0, we: d_we, access: d_access, addr: d_addr, wdata: d_wdata};
            streak_d = !if_req ? 4'd0 : ((streak_q >= LIMIT) ? LIMIT : streak_q + 4'd1);
        end
    end

    // State, command and streak registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            streak_q <= streak_d;
        end
    end

    // Port outputs: memory command in ISSUE, response in RESP, all zero under reset.
    always_comb begin
        if_gnt     = grant_if;
        d_gnt      = grant_d;
        if_rvalid  = 1'b0;
        if_rdata   = 32'd0;
        d_rvalid   = 1'b0;
        d_rdata    = 32'd0;
        mem_load   = 1'b0;
        mem_store  = 1'b0;
        mem_access = '0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        busy       = rst && (state_q != IDLE);
        if (rst && (state_q == ISSUE)) begin
            mem_load   = cmd_q.is_fetch || !cmd_q.we;
            mem_store  = !cmd_q.is_fetch && cmd_q.we;
            mem_access = cmd_q.access;
            mem_addr   = cmd_q.addr;
            mem_wdata  = cmd_q.wdata;
        end
        if (rst && (state_q == RESP)) begin
            if (cmd_q.is_fetch) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                d_rvalid = 1'b1;
                d_rdata  = cmd_q.we ? 32'd0 : mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_q, stat_if_d;
    logic [31:0] stat_d_q, stat_d_d;
    logic [31:0] stat_cont_q, stat_cont_d;

    // Free-running wrap-around event counters.
    always_comb begin
        stat_if_d   = stat_if_q + 32'(grant_if);
        stat_d_d    = stat_d_q + 32'(grant_d);
        stat_cont_d = stat_cont_q + 32'(if_req && d_req && !grant_if);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_if_q   <= 32'd0;
            stat_d_q    <= 32'd0;
            stat_cont_q <= 32'd0;
        end else begin
            stat_if_q   <= stat_if_d;
            stat_d_q    <= stat_d_d;
            stat_cont_q <= stat_cont_d;
        end
    end

    assign stat_if_grants = stat_if_q;
    assign stat_d_grants  = stat_d_q;
    assign stat_contended = stat_cont_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized transaction model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: stimulus holds each request until the model predicts its grant.
module tb_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_access;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_load, mem_store;
    logic [2:0]  mem_access;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_grants, stat_d_grants, stat_contended;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_access(d_access), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_load(mem_load), .mem_store(mem_store), .mem_access(mem_access),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants(stat_if_grants), .stat_d_grants(stat_d_grants),
        .stat_contended(stat_contended)
`endif
    );

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_access = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
        mem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic logic [133:0] all_outs();
        return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                mem_load, mem_store, mem_access, mem_addr, mem_wdata, busy};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if_req = 1'b1; d_req = 1'b1; if_addr = $urandom; d_addr = $urandom;
            d_we = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk);
            n_checks++;
            if (all_outs() !== '0) $display("FAIL reset_outs cyc%0d: got %h want 0", c, all_outs());
            else n_pass++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (all_outs() !== '0) $display("FAIL after_reset_outs: got %h want 0", all_outs());
        else n_pass++;
`ifdef MEM_ARB_STATS_EN
        n_checks++;
        if ({stat_if_grants, stat_d_grants, stat_contended} !== 96'd0)
            $display("FAIL reset_stats: got %h want 0", {stat_if_grants, stat_d_grants, stat_contended});
        else n_pass++;
`endif
    endtask

    task automatic test_fetch_alone();
        do_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, d_gnt, busy, mem_load} !== 4'b1000)
            $display("FAIL fetch_c0: got %b want 1000", {if_gnt, d_gnt, busy, mem_load});
        else n_pass++;
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, mem_load, mem_store, mem_access, mem_addr, mem_wdata} !== {1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0})
            $display("FAIL fetch_c1: got %h want %h", {if_gnt, mem_load, mem_store, mem_access, mem_addr, mem_wdata},
                     {1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0});
        else n_pass++;
        @(posedge clk); #1;
        mem_rdata = 32'h00500513;
        @(negedge clk);
        n_checks++;
        if ({if_rvalid, if_rdata, d_rvalid, mem_load} !== {1'b1, 32'h00500513, 1'b0, 1'b0})
            $display("FAIL fetch_c2: got %h want %h", {if_rvalid, if_rdata, d_rvalid, mem_load},
                     {1'b1, 32'h00500513, 1'b0, 1'b0});
        else n_pass++;
        @(posedge clk); #1;
        mem_rdata = 32'd0;
        @(negedge clk);
        n_checks++;
        if ({busy, if_rvalid} !== 2'b00) $display("FAIL fetch_c3: got %b want 00", {busy, if_rvalid});
        else n_pass++;
    endtask

    task automatic test_store();
        do_reset();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_access = 3'b010;
        @(negedge clk);
        n_checks++;
        if ({d_gnt, if_gnt} !== 2'b10) $display("FAIL store_gnt: got %b want 10", {d_gnt, if_gnt});
        else n_pass++;
        @(posedge clk); #1;
        d_req = 1'b0; d_wdata = 32'd0; d_addr = 32'd0;
        @(negedge clk);
        n_checks++;
        if ({mem_load, mem_store, mem_access, mem_addr, mem_wdata} !== {1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF})
            $display("FAIL store_cmd: got %h want %h", {mem_load, mem_store, mem_access, mem_addr, mem_wdata},
                     {1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF});
        else n_pass++;
        @(posedge clk); #1;
        mem_rdata = 32'hA5A5_1234;
        @(negedge clk);
        n_checks++;
        if ({d_rvalid, d_rdata, if_rvalid, mem_store} !== {1'b1, 32'h0, 1'b0, 1'b0})
            $display("FAIL store_resp: got %h want %h", {d_rvalid, d_rdata, if_rvalid, mem_store},
                     {1'b1, 32'h0, 1'b0, 1'b0});
        else n_pass++;
    endtask

    task automatic test_starve();
        bit pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        logic [1:0] exp_g;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if_req = 1'b1; if_addr = 32'h40 + 32'(c);
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200 + 32'(c);
            @(negedge clk);
            exp_g = (c % 2 != 0) ? 2'b00 : (pat[c / 2] ? 2'b10 : 2'b01);
            n_checks++;
            if ({if_gnt, d_gnt} !== exp_g) $display("FAIL starve_cyc%0d: got %b want %b", c, {if_gnt, d_gnt}, exp_g);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_issue();
        do_reset();
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_access = 3'b100;
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1) $display("FAIL rii_gnt: got %b want 1", d_gnt);
        else n_pass++;
        @(posedge clk); #1;
        d_req = 1'b0; rst = 1'b0; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        n_checks++;
        if (all_outs() !== '0) $display("FAIL rii_during: got %h want 0", all_outs());
        else n_pass++;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({busy, d_rvalid, if_rvalid, mem_load, mem_store} !== 5'b0)
                $display("FAIL rii_after%0d: got %b want 00000", c, {busy, d_rvalid, if_rvalid, mem_load, mem_store});
            else n_pass++;
        end
    endtask

    task automatic test_streak_clear();
        logic [1:0] exp_g;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if_req = (c != 6); if_addr = 32'h500;
            d_req = (c < 17); d_we = 1'b0; d_addr = 32'h600 + 32'(c);
            @(negedge clk);
            if (c % 2 != 0) exp_g = 2'b00;
            else if (c == 16 || c == 18) exp_g = 2'b10;
            else exp_g = 2'b01;
            n_checks++;
            if ({if_gnt, d_gnt} !== exp_g) $display("FAIL streak_cyc%0d: got %b want %b", c, {if_gnt, d_gnt}, exp_g);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit iss_v = 0, iss_f = 0, iss_we = 0, rsp_v = 0, rsp_f = 0, rsp_we = 0;
        logic [2:0]  iss_acc = '0;
        logic [31:0] iss_addr = '0, iss_wd = '0;
        int run = 0;
        bit e_if = 0, e_d = 0;
        logic [68:0] exp_mem;
        logic [65:0] exp_rsp;
        int s_if = 0, s_d = 0, s_cont = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 149) != 0);
            if (!(if_req && !e_if && $urandom_range(0, 7) != 0)) begin
                if_req = 1'($urandom); if_addr = $urandom;
            end
            if (!(d_req && !e_d && $urandom_range(0, 7) != 0)) begin
                d_req = 1'($urandom); d_we = 1'($urandom); d_access = 3'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            // Arbitration possible unless an access is being issued this cycle.
            e_if = rst && !iss_v && if_req && (!d_req || run >= LIM);
            e_d  = rst && !iss_v && d_req && !e_if;
            exp_mem = '0;
            if (rst && iss_v) exp_mem = {iss_f || !iss_we, !iss_f && iss_we, iss_acc, iss_addr, iss_wd};
            exp_rsp = '0;
            if (rst && rsp_v) begin
                if (rsp_f) exp_rsp = {1'b1, mem_rdata, 1'b0, 32'd0};
                else       exp_rsp = {1'b0, 32'd0, 1'b1, rsp_we ? 32'd0 : mem_rdata};
            end
            @(negedge clk);
            n_checks++;
            if ({if_gnt, d_gnt} !== {e_if, e_d}) $display("FAIL rnd_gnt cyc%0d: got %b want %b", c, {if_gnt, d_gnt}, {e_if, e_d});
            else n_pass++;
            n_checks++;
            if ({mem_load, mem_store, mem_access, mem_addr, mem_wdata} !== exp_mem)
                $display("FAIL rnd_mem cyc%0d: got %h want %h", c, {mem_load, mem_store, mem_access, mem_addr, mem_wdata}, exp_mem);
            else n_pass++;
            n_checks++;
            if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== exp_rsp)
                $display("FAIL rnd_rsp cyc%0d: got %h want %h", c, {if_rvalid, if_rdata, d_rvalid, d_rdata}, exp_rsp);
            else n_pass++;
            n_checks++;
            if (busy !== (rst && (iss_v || rsp_v))) $display("FAIL rnd_busy cyc%0d: got %b want %b", c, busy, rst && (iss_v || rsp_v));
            else n_pass++;
            if (!rst) begin
                iss_v = 0; rsp_v = 0; run = 0; s_if = 0; s_d = 0; s_cont = 0;
            end else begin
                rsp_v = iss_v; rsp_f = iss_f; rsp_we = iss_we;
                iss_v = e_if || e_d;
                iss_f = e_if;
                iss_we = e_d && d_we;
                iss_acc = e_if ? 3'b010 : d_access;
                iss_addr = e_if ? if_addr : d_addr;
                iss_wd = e_if ? 32'd0 : d_wdata;
                if (e_if) run = 0;
                else if (e_d) run = if_req ? ((run + 1 > LIM) ? LIM : run + 1) : 0;
                s_if += int'(e_if);
                s_d += int'(e_d);
                s_cont += int'(if_req && d_req && !e_if);
            end
        end
`ifdef MEM_ARB_STATS_EN
        @(posedge clk); #1;
        rst = 1'b1; idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({stat_if_grants, stat_d_grants, stat_contended} !== {32'(s_if), 32'(s_d), 32'(s_cont)})
            $display("FAIL rnd_stats: got %h want %h", {stat_if_grants, stat_d_grants, stat_contended},
                     {32'(s_if), 32'(s_d), 32'(s_cont)});
        else n_pass++;
`endif
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_fetch_alone();
        test_store();
        test_starve();
        test_reset_in_issue();
        test_streak_clear();
        test_random();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
